i2c_write_sequencer: RTL and testbench
======================================

Name: i2c_write_sequencer

Overview:
Transaction-level controller for the I2C byte writer. Accepts a host write request (7-bit device address, N payload bytes) and sequences it as START, address+W, slave ACK, payload bytes each followed by slave ACK, then STOP. It drives the byte writer's go/command/serial-data interface and a 1-bit ACK-receive unit, and reports completion and error status to the host.

Parameters:
LEN_W, 8, width of byte_count; a transaction carries 0..2^LEN_W-1 payload bytes.
TIMEOUT_CYC, 4096, maximum cycles to wait on any finish edge before abort.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
dev_addr  input  7  slave address, latched on accepted start
byte_count  input  LEN_W  payload byte count, latched on accepted start
wr_data  input  8  payload byte from host
wr_valid  input  1  wr_data valid
wr_ready  output  1  one-cycle pulse: wr_data captured this cycle
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of transaction
error  output  2  00 ok, 01 address NACK, 10 data NACK, 11 timeout; valid with done, held until next accepted start
wb_go  output  1  byte writer go
wb_command  output  3  001 START, 011 DATA byte, 100 STOP (101/111 never issued)
wb_data  output  1  serial bit to writer = shift_reg[7]
wb_load  input  1  writer bit request, active low: shift_reg shifts left (LSB fill 0) on every cycle wb_load=0 while in DATA state
wb_finish  input  1  writer operation complete
ack_go  output  1  ACK-receive unit go
ack_finish  input  1  ACK-receive complete
ack_bit  input  1  sampled SDA during ACK slot; 0 = ACK, 1 = NACK

Behaviour:
- Reset (next edge): state IDLE, wb_go 0, wb_command 000, shift_reg 8'hFF (wb_data 1), ack_go 0, busy 0, done 0, wr_ready 0, error 00, counters 0. Reset mid-transaction aborts immediately; no STOP issued.
- States: IDLE, START, ADDR, ACK, LOAD, DATA, STOP, FIN. Every writer/ACK state has two phases: ISSUE (go held 1 until finish=1) then RELEASE (go 0 until finish=0); transition happens on the cycle finish=0 is seen in RELEASE. wb_command is stable for the whole ISSUE+RELEASE window.
- IDLE: start=1 -> latch dev_addr, byte_count, clear error, busy=1, -> START (wb_command 001). start while busy ignored.
- START -> ADDR: shift_reg loaded with {dev_addr,1'b0} on entry, command 011.
- ADDR -> ACK. ACK: ack_go until ack_finish; ack_bit captured on the first cycle ack_finish=1.
- After ACK: NACK following address -> error 01, STOP. NACK following data -> error 10, STOP. ACK with remaining=0 -> STOP. Otherwise -> LOAD.
- LOAD: wr_ready asserted combinationally-free as a registered pulse in the cycle wr_valid=1 is seen; shift_reg<=wr_data, remaining decremented, -> DATA. wr_valid=0 -> wait indefinitely (no timeout; bus stretched idle by writer).
- DATA -> ACK. STOP (command 100) -> FIN. FIN: done=1 for one cycle, busy=0, -> IDLE.
- Timeout: counter clears on each phase entry; reaching TIMEOUT_CYC in ISSUE or RELEASE of any writer/ACK state -> go outputs 0, error 11, FIN (no STOP).
- byte_count=0: START, ADDR, ACK, STOP; wr_ready never asserted.
- shift_reg does not shift outside DATA/ADDR states regardless of wb_load.

Test Plan:
- dev_addr 7'h50, byte_count 2, bytes A5,3C, ack_bit 0 always -> commands 001,011,ACK,011,ACK,011,ACK,100; wb_data at load strobes 10100000,10100101,00111100; two wr_ready pulses; done with error 00.
- dev_addr 7'h21, byte_count 3, ack_bit 1 on address -> 001,011,ACK,100; error 01; wr_ready never pulses.
- byte_count 0, dev_addr 7'h7F -> address byte FE serialized, STOP, error 00.
- byte_count 3, NACK after second data byte -> STOP after it, error 10, exactly 2 wr_ready pulses.
- wb_finish stuck 0 after START go -> wb_go drops at TIMEOUT_CYC, done, error 11, busy 0; wr_valid held low 50 cycles in LOAD -> no timeout, resumes on valid.
- reset asserted mid-DATA -> all outputs at reset values next cycle; start pulsed while busy -> ignored, latched address unchanged.

Source files
------------

// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer: sequences START, address, ACK-checked payload bytes and STOP over an I2C byte writer
module i2c_write_sequencer #(
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       dev_addr,
  input  logic [LEN_W-1:0] byte_count,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       error,
  output logic             wb_go,
  output logic [2:0]       wb_command,
  output logic             wb_data,
  input  logic             wb_load,
  input  logic             wb_finish,
  output logic             ack_go,
  input  logic             ack_finish,
  input  logic             ack_bit
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK, LOAD, DATA, STOP, FIN} state_t;

  state_t           state_q, state_d;
  logic             rel_q, rel_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [7:0]       shift_q, shift_d;
  logic [6:0]       addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       err_q, err_d;
  logic             nack_q, nack_d;
  logic             first_q, first_d;
  logic             rdy_q, rdy_d;
  logic             hs, fin_ok, tmo_hit;

  assign hs      = state_q inside {START, ADDR, ACK, DATA, STOP};
  assign fin_ok  = ((state_q == ACK) ? ack_finish : wb_finish) ^ rel_q;
  assign tmo_hit = tmo_q == TW'(TIMEOUT_CYC - 1);

  // next state: each handshake state is an ISSUE phase (go until finish) then a RELEASE phase (until finish drops)
  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    tmo_d   = hs ? tmo_q + 1'b1 : '0;
    shift_d = (state_q inside {ADDR, DATA}) && !wb_load ? {shift_q[6:0], 1'b0} : shift_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    nack_d  = nack_q;
    first_d = first_q;
    rdy_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = dev_addr;
        rem_d   = byte_count;
        err_d   = 2'b00;
        first_d = 1'b1;
        rel_d   = 1'b0;
        state_d = START;
      end
      LOAD: if (wr_valid) begin
        shift_d = wr_data;
        rem_d   = rem_q - 1'b1;
        rdy_d   = 1'b1;
        state_d = DATA;
      end
      FIN: state_d = IDLE;
      default: if (fin_ok) begin
        tmo_d = '0;
        rel_d = !rel_q;
        if (!rel_q) nack_d = (state_q == ACK) ? ack_bit : nack_q;
        else case (state_q)
          START: begin
            state_d = ADDR;
            shift_d = {addr_q, 1'b0};
          end
          ACK: begin
            state_d = nack_q || rem_q == '0 ? STOP : LOAD;
            err_d   = !nack_q ? err_q : first_q ? 2'b01 : 2'b10;
            first_d = 1'b0;
          end
          STOP:    state_d = FIN;
          default: state_d = ACK;
        endcase
      end else if (tmo_hit) begin
        state_d = FIN;
        rel_d   = 1'b0;
        tmo_d   = '0;
        err_d   = 2'b11;
      end
    endcase
  end

  // state register with synchronous reset; reset abandons any transaction without a STOP
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rel_q   <= 1'b0;
      tmo_q   <= '0;
      shift_q <= 8'hFF;
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 2'b00;
      nack_q  <= 1'b0;
      first_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      tmo_q   <= tmo_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      nack_q  <= nack_d;
      first_q <= first_d;
      rdy_q   <= rdy_d;
    end
  end

  assign wb_go      = (state_q inside {START, ADDR, DATA, STOP}) && !rel_q;
  assign ack_go     = state_q == ACK && !rel_q;
  assign wb_command = state_q == START ? 3'b001 : (state_q inside {ADDR, DATA}) ? 3'b011 : state_q == STOP ? 3'b100 : 3'b000;
  assign wb_data    = shift_q[7];
  assign busy       = state_q != IDLE && state_q != FIN;
  assign done       = state_q == FIN;
  assign error      = err_q;
  assign wr_ready   = rdy_q;
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// tb_i2c_write_sequencer: randomized writer/ACK/host responders checked against a transaction-level model
module tb_i2c_write_sequencer;
  localparam int TO = 40;
  localparam logic [2:0] C_ACK = 3'b111;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, wr_valid = 1'b0;
  logic wb_load = 1'b1, wb_finish = 1'b0, ack_finish = 1'b0, ack_bit = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] byte_count = '0, wr_data = '0;
  logic wr_ready, busy, done, wb_go, wb_data, ack_go;
  logic [1:0] error;
  logic [2:0] wb_command;

  int checks = 0, errors = 0;
  logic [2:0] exp_seq[$];
  logic [7:0] exp_bytes[$], obs_bytes[$], payload[$];
  logic [1:0] exp_err = '0, held_err = '0;
  int exp_rdy = 0, rdy_cnt = 0, nack_at = -1, ack_idx = 0, hold = 0, go_run = 0, last_run = 0, r_bits = 0;
  bit stuck = 0, m_busy = 0, prev_go = 0, prev_ack = 0;
  logic [2:0] cur_cmd = '0;
  logic [7:0] r_sh = '0;

  i2c_write_sequencer #(.LEN_W(8), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .dev_addr(dev_addr), .byte_count(byte_count),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .busy(busy), .done(done),
    .error(error), .wb_go(wb_go), .wb_command(wb_command), .wb_data(wb_data), .wb_load(wb_load),
    .wb_finish(wb_finish), .ack_go(ack_go), .ack_finish(ack_finish), .ack_bit(ack_bit)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected operation list, serialized bytes, error and wr_ready count for one transaction
  task automatic build(input logic [6:0] a, input int n, input int nk, input bit stk);
    int k = 0;
    exp_seq.delete();
    exp_bytes.delete();
    exp_seq.push_back(3'b001);
    if (stk) begin
      exp_err = 2'b11;
      exp_rdy = 0;
      return;
    end
    exp_seq.push_back(3'b011);
    exp_bytes.push_back({a, 1'b0});
    exp_seq.push_back(C_ACK);
    while (k < n && nk != k) begin
      exp_seq.push_back(3'b011);
      exp_seq.push_back(C_ACK);
      exp_bytes.push_back(payload[k]);
      k++;
    end
    exp_err = (nk == k) ? ((k == 0) ? 2'b01 : 2'b10) : 2'b00;
    exp_seq.push_back(3'b100);
    exp_rdy = k;
  endtask

  // byte writer and ACK unit: random latencies, bit-by-bit capture of the serial data
  initial forever begin
    @(posedge clock); #1;
    wb_load = 1'b1;
    if (reset) begin
      wb_finish = 1'b0;
      ack_finish = 1'b0;
      r_bits = 0;
    end else begin
      if (wb_go && !wb_finish) begin
        if (wb_command == 3'b011 && r_bits < 8) begin
          if ($urandom_range(3) != 0) begin
            wb_load = 1'b0;
            r_sh = {r_sh[6:0], wb_data};
            r_bits++;
            if (r_bits == 8) obs_bytes.push_back(r_sh);
          end
        end else if (!(stuck && wb_command == 3'b001) && $urandom_range(2) == 0) begin
          wb_finish = 1'b1;
          r_bits = 0;
        end
      end else if (!wb_go && wb_finish && $urandom_range(1) == 0) wb_finish = 1'b0;
      if (ack_go && !ack_finish && $urandom_range(2) == 0) begin
        ack_finish = 1'b1;
        ack_bit = (ack_idx == nack_at);
        ack_idx++;
      end else begin
        ack_bit = 1'($urandom);
        if (!ack_go && ack_finish && $urandom_range(1) == 0) ack_finish = 1'b0;
      end
    end
  end

  // host: offers the payload queue, advancing on wr_ready
  initial forever begin
    @(posedge clock); #1;
    if (reset || payload.size() == 0) wr_valid = 1'b0;
    else begin
      if (wr_ready) begin
        void'(payload.pop_front());
        wr_valid = 1'b0;
        hold = $urandom_range(3);
      end
      if (payload.size() == 0) wr_valid = 1'b0;
      else if (wr_valid) wr_data = payload[0];
      else if (hold > 0) hold--;
      else begin
        wr_valid = 1'b1;
        wr_data = payload[0];
      end
    end
  end

  // per-cycle comparison against the transaction model
  initial forever begin
    @(negedge clock);
    if (reset) begin
      m_busy = 0;
      prev_go = 0;
      prev_ack = 0;
      go_run = 0;
      held_err = '0;
    end else begin
      check("go_exclusive", 32'(wb_go & ack_go), 0);
      if (wb_go && !prev_go) begin
        cur_cmd = wb_command;
        if (exp_seq.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_op: got command %0h expected none", wb_command);
        end else check("op", 32'(wb_command), 32'(exp_seq.pop_front()));
      end
      if (wb_go) check("cmd_stable", 32'(wb_command), 32'(cur_cmd));
      if (ack_go && !prev_ack) begin
        if (exp_seq.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_op: got ack expected none");
        end else check("op", 32'(C_ACK), 32'(exp_seq.pop_front()));
      end
      if (wb_go) go_run++;
      else if (go_run > 0) begin
        last_run = go_run;
        go_run = 0;
      end
      if (wr_ready) begin
        rdy_cnt++;
        check("wr_ready_extra", 32'(rdy_cnt <= exp_rdy), 1);
      end
      if (done) begin
        check("busy_at_done", 32'(busy), 0);
        check("done_in_txn", 32'(m_busy), 1);
        check("error", 32'(error), 32'(exp_err));
        check("wr_ready_count", rdy_cnt, exp_rdy);
        check("ops_left", exp_seq.size(), 0);
        check("bytes_sent", obs_bytes.size(), exp_bytes.size());
        for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++) check("byte", 32'(obs_bytes[i]), 32'(exp_bytes[i]));
        m_busy = 0;
        held_err = exp_err;
      end else if (m_busy) check("busy", 32'(busy), 1);
      else begin
        check("idle_busy", 32'(busy), 0);
        check("idle_quiet", 32'({wb_go, ack_go, wr_ready}), 0);
        check("error_held", 32'(error), 32'(held_err));
        if (start) begin
          m_busy = 1;
          rdy_cnt = 0;
          obs_bytes.delete();
        end
      end
      prev_go = wb_go;
      prev_ack = ack_go;
    end
  end

  task automatic wait_done(input int max);
    bit seen = 0;
    repeat (max) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", max);
    end
    @(negedge clock);
  endtask

  task automatic launch(input logic [6:0] a, input int n, input logic [7:0] d[$], input int nk, input bit stk, input int dly, input bit poke);
    payload.delete();
    repeat (2) @(posedge clock);
    #1;
    payload = d;
    nack_at = nk;
    stuck = stk;
    ack_idx = 0;
    hold = dly;
    build(a, n, nk, stk);
    start = 1'b1;
    dev_addr = a;
    byte_count = 8'(n);
    @(posedge clock); #1;
    start = 1'b0;
    dev_addr = ~a;
    byte_count = 8'($urandom);
    if (poke) begin
      repeat (2) @(posedge clock);
      #1 start = 1'b1;
      dev_addr = 7'($urandom);
      byte_count = 8'($urandom);
      @(posedge clock); #1 start = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_wb_go"}, 32'(wb_go), 0);
    check({tag, "_wb_command"}, 32'(wb_command), 0);
    check({tag, "_wb_data"}, 32'(wb_data), 1);
    check({tag, "_ack_go"}, 32'(ack_go), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_wr_ready"}, 32'(wr_ready), 0);
  endtask

  initial begin
    logic [7:0] d[$];
    int n, nk;
    bit seen;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset");

    d = '{8'hA5, 8'h3C};
    launch(7'h50, 2, d, -1, 0, 0, 0);
    wait_done(3000);
    check("t1_addr_byte", 32'(obs_bytes[0]), 32'h A0);
    check("t1_byte0", 32'(obs_bytes[1]), 32'hA5);
    check("t1_byte1", 32'(obs_bytes[2]), 32'h3C);
    check("t1_ready", rdy_cnt, 2);
    check("t1_error", 32'(error), 0);

    d = '{8'h01, 8'h02, 8'h03};
    launch(7'h21, 3, d, 0, 0, 0, 0);
    wait_done(3000);
    check("t2_error", 32'(error), 1);
    check("t2_ready", rdy_cnt, 0);

    d.delete();
    launch(7'h7F, 0, d, -1, 0, 0, 0);
    wait_done(3000);
    check("t3_addr_byte", 32'(obs_bytes[0]), 32'hFE);
    check("t3_bytes", obs_bytes.size(), 1);
    check("t3_error", 32'(error), 0);

    d = '{8'h11, 8'h22, 8'h33};
    launch(7'h33, 3, d, 2, 0, 0, 0);
    wait_done(3000);
    check("t4_error", 32'(error), 2);
    check("t4_ready", rdy_cnt, 2);

    d = '{8'h44};
    launch(7'h12, 1, d, -1, 1, 0, 0);
    wait_done(3000);
    check("t5_error", 32'(error), 3);
    check("t5_busy", 32'(busy), 0);
    check("t5_go_cycles", last_run, TO);

    d = '{8'h5A, 8'hC3};
    launch(7'h0C, 2, d, -1, 0, 200, 0);
    wait_done(3000);
    check("t6_error", 32'(error), 0);
    check("t6_ready", rdy_cnt, 2);

    d = '{8'h99};
    launch(7'h15, 1, d, -1, 0, 0, 1);
    wait_done(3000);
    check("t7_addr_byte", 32'(obs_bytes[0]), 32'h2A);

    d = '{8'hF0, 8'h0F, 8'hAA};
    launch(7'h44, 3, d, -1, 0, 0, 0);
    seen = 0;
    repeat (1000) begin
      @(negedge clock);
      if (wr_ready) begin
        seen = 1;
        break;
      end
    end
    check("t8_reached_data", 32'(seen), 1);
    check("t8_in_data", 32'(wb_command), 3);
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_outputs("t8");
    @(posedge clock); #1 reset = 1'b0;
    repeat (20) @(negedge clock);

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(5);
      d.delete();
      for (int j = 0; j < n; j++) d.push_back(8'($urandom));
      nk = ($urandom_range(3) == 0) ? int'($urandom_range(n)) : -1;
      launch(7'($urandom), n, d, nk, 0, $urandom_range(6), $urandom_range(4) == 0);
      wait_done(3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
